// File: rtl/data_producer_if.sv
// -----------------------------------------------------------------------------
// data_producer_if
//   AXI-Stream transmit bundle driven by data_producer.
//
//   Parameter:
//     DW              data width in bits (32/64/128/256/512)
//
//   Signals:
//     AXIS_TX_TDATA   DW     payload
//     AXIS_TX_TKEEP   DW/8   byte enables
//     AXIS_TX_TUSER   1      start-of-packet marker
//     AXIS_TX_TLAST   1      last beat of packet
//     AXIS_TX_TVALID  1      beat valid
//     AXIS_TX_TREADY  1      downstream ready
//
//   Modports:
//     master  the packet source (drives data/valid, samples ready)
//     slave   the downstream sink
// -----------------------------------------------------------------------------
interface data_producer_if #(
    parameter int DW = 32
);
    logic [DW-1:0]   AXIS_TX_TDATA;
    logic [DW/8-1:0] AXIS_TX_TKEEP;
    logic            AXIS_TX_TUSER;
    logic            AXIS_TX_TLAST;
    logic            AXIS_TX_TVALID;
    logic            AXIS_TX_TREADY;

    modport master (
        output AXIS_TX_TDATA,
        output AXIS_TX_TKEEP,
        output AXIS_TX_TUSER,
        output AXIS_TX_TLAST,
        output AXIS_TX_TVALID,
        input  AXIS_TX_TREADY
    );

    modport slave (
        input  AXIS_TX_TDATA,
        input  AXIS_TX_TKEEP,
        input  AXIS_TX_TUSER,
        input  AXIS_TX_TLAST,
        input  AXIS_TX_TVALID,
        output AXIS_TX_TREADY
    );
endinterface

// File: rtl/data_producer.sv
// -----------------------------------------------------------------------------
// data_producer
//   Dummy AXI-Stream packet source. A start pulse launches packet_count
//   packets of packet_len bytes each. Payload is a 32-bit word replicated
//   across the bus; by default an incrementing beat counter, or with the
//   macro DATA_PRODUCER_PRBS_EN defined, a 32-bit Galois LFSR
//   (x^32+x^22+x^2+x+1, seeded 0xFFFFFFFF on start). Optional throttling
//   inserts NVALID_CYCLES idle clocks after every VALID_CYCLES accepted beats.
//
//   Parameters:
//     DW             data width (32/64/128/256/512)
//     VALID_CYCLES   accepted beats between throttle gaps
//     NVALID_CYCLES  gap length in clocks; 0 disables throttling
//
//   Ports:
//     clk            clock
//     resetn         synchronous, active-low reset
//     start          one-cycle command pulse (honoured only when idle)
//     packet_len     bytes per packet, sampled on start
//     packet_count   packets per command, sampled on start
//     busy           high while a command is executing
//     done           one-cycle pulse on command completion
//     axis_tx        AXI-Stream master (data_producer_if.master)
// -----------------------------------------------------------------------------
module data_producer #(
    parameter int DW            = 32,
    parameter int VALID_CYCLES  = 0,
    parameter int NVALID_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [15:0]            packet_len,
    input  logic [31:0]            packet_count,
    output logic                   busy,
    output logic                   done,
    data_producer_if.master        axis_tx
);
    localparam int BPB     = DW / 8;
    localparam int BPB_LOG = $clog2(BPB);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

`ifdef DATA_PRODUCER_PRBS_EN
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] SEED = 32'h0000_0000;
`endif

    logic [1:0]  state_reg,     state_next;
    logic [15:0] len_reg,       len_next;
    logic [31:0] count_reg,     count_next;
    logic [15:0] beat_reg,      beat_next;      // beat index inside current packet
    logic [31:0] pkt_reg,       pkt_next;       // packet index inside command
    logic [31:0] seq_reg,       seq_next;       // payload word for current beat
    logic [31:0] since_gap_reg, since_gap_next; // accepted beats since last gap
    logic [31:0] gap_cnt_reg,   gap_cnt_next;
    logic        done_reg,      done_next;

    logic        tvalid;
    logic        handshake;
    logic        last_beat;
    logic        final_pkt;
    logic [16:0] len_round;
    logic [16:0] beats_per_pkt;
    logic [BPB_LOG-1:0] rem;
    logic [31:0] seq_adv;
    logic [BPB-1:0] keep_bits;
    logic [DW-1:0]  data_bits;

    // TVALID falls combinationally with resetn so a reset never leaves a
    // dangling beat on the bus for the extra cycle a register would add.
    assign tvalid    = resetn & (state_reg == SEND);
    assign handshake = tvalid & axis_tx.AXIS_TX_TREADY;

    // Beat count is derived from the latched length; BPB is a power of two.
    assign len_round     = {1'b0, len_reg} + 17'(BPB - 1);
    assign beats_per_pkt = len_round >> BPB_LOG;
    assign last_beat     = ({1'b0, beat_reg} == (beats_per_pkt - 17'd1));
    assign final_pkt     = (pkt_reg == (count_reg - 32'd1));
    assign rem           = len_reg[BPB_LOG-1:0];

`ifdef DATA_PRODUCER_PRBS_EN
    // Right-shifting Galois form; tap mask bits 31,21,1,0 encode x^32,x^22,x^2,x.
    assign seq_adv = {1'b0, seq_reg[31:1]} ^ (seq_reg[0] ? 32'h8020_0003 : 32'h0);
`else
    assign seq_adv = seq_reg + 32'd1;
`endif

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        count_next     = count_reg;
        beat_next      = beat_reg;
        pkt_next       = pkt_reg;
        seq_next       = seq_reg;
        since_gap_next = since_gap_reg;
        gap_cnt_next   = gap_cnt_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                // done_reg marks the completion cycle, where start is ignored.
                if (start && !done_reg) begin
                    len_next       = packet_len;
                    count_next     = packet_count;
                    beat_next      = 16'd0;
                    pkt_next       = 32'd0;
                    seq_next       = SEED;
                    since_gap_next = 32'd0;
                    gap_cnt_next   = 32'd0;
                    if (packet_len == 16'd0 || packet_count == 32'd0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = SEND;
                    end
                end
            end

            SEND: begin
                if (handshake) begin
                    seq_next       = seq_adv;
                    since_gap_next = since_gap_reg + 32'd1;
                    if (last_beat) begin
                        beat_next = 16'd0;
                        pkt_next  = pkt_reg + 32'd1;
                    end else begin
                        beat_next = beat_reg + 16'd1;
                    end

                    if (last_beat && final_pkt) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else if ((NVALID_CYCLES != 0) &&
                                 ((since_gap_reg + 32'd1) >= 32'(VALID_CYCLES))) begin
                        state_next   = GAP;
                        gap_cnt_next = 32'd0;
                    end
                end
            end

            GAP: begin
                if (gap_cnt_reg == 32'(NVALID_CYCLES - 1)) begin
                    state_next     = SEND;
                    since_gap_next = 32'd0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 32'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            len_reg       <= 16'd0;
            count_reg     <= 32'd0;
            beat_reg      <= 16'd0;
            pkt_reg       <= 32'd0;
            seq_reg       <= 32'd0;
            since_gap_reg <= 32'd0;
            gap_cnt_reg   <= 32'd0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            count_reg     <= count_next;
            beat_reg      <= beat_next;
            pkt_reg       <= pkt_next;
            seq_reg       <= seq_next;
            since_gap_reg <= since_gap_next;
            gap_cnt_reg   <= gap_cnt_next;
            done_reg      <= done_next;
        end
    end

    // Per-lane keep and payload. Only the final beat of a packet is partial;
    // a zero remainder means that beat is full.
    genvar gi;
    generate
        for (gi = 0; gi < BPB; gi++) begin : g_lane
            assign keep_bits[gi] = !last_beat || (rem == '0) || (BPB_LOG'(gi) < rem);
            assign data_bits[8*gi +: 8] = keep_bits[gi] ? seq_reg[8*(gi % 4) +: 8] : 8'h00;
        end
    endgenerate

    // Payload outputs are zero whenever no beat is presented, which also
    // yields the reset values while resetn is low.
    assign axis_tx.AXIS_TX_TVALID = tvalid;
    assign axis_tx.AXIS_TX_TDATA  = tvalid ? data_bits : '0;
    assign axis_tx.AXIS_TX_TKEEP  = tvalid ? keep_bits : '0;
    assign axis_tx.AXIS_TX_TUSER  = tvalid & (beat_reg == 16'd0);
    assign axis_tx.AXIS_TX_TLAST  = tvalid & last_beat;

    assign busy = resetn & (state_reg != IDLE);
    assign done = resetn & done_reg;

endmodule

// File: tb/tb_data_producer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_data_producer
//   Three producers: u0 (DW=32), u1 (DW=64), u2 (DW=32, 2 beats / 3 gap).
//   One producer is active at a time; a reference model expands each command
//   into the expected beat list and a negedge monitor scores every handshake.
// -----------------------------------------------------------------------------
module tb_data_producer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        start_v [3];
    logic [15:0] len_v   [3];
    logic [31:0] cnt_v   [3];
    logic        rdy_v   [3];

    logic [511:0] o_data  [3];
    logic [63:0]  o_keep  [3];
    logic         o_user  [3];
    logic         o_last  [3];
    logic         o_valid [3];
    logic         o_busy  [3];
    logic         o_done  [3];

    data_producer_if #(.DW(32)) if0 ();
    data_producer_if #(.DW(64)) if1 ();
    data_producer_if #(.DW(32)) if2 ();

    data_producer #(.DW(32), .VALID_CYCLES(0), .NVALID_CYCLES(0)) u0 (
        .clk(clk), .resetn(resetn), .start(start_v[0]), .packet_len(len_v[0]),
        .packet_count(cnt_v[0]), .busy(o_busy[0]), .done(o_done[0]), .axis_tx(if0));
    data_producer #(.DW(64), .VALID_CYCLES(0), .NVALID_CYCLES(0)) u1 (
        .clk(clk), .resetn(resetn), .start(start_v[1]), .packet_len(len_v[1]),
        .packet_count(cnt_v[1]), .busy(o_busy[1]), .done(o_done[1]), .axis_tx(if1));
    data_producer #(.DW(32), .VALID_CYCLES(2), .NVALID_CYCLES(3)) u2 (
        .clk(clk), .resetn(resetn), .start(start_v[2]), .packet_len(len_v[2]),
        .packet_count(cnt_v[2]), .busy(o_busy[2]), .done(o_done[2]), .axis_tx(if2));

    assign if0.AXIS_TX_TREADY = rdy_v[0];
    assign if1.AXIS_TX_TREADY = rdy_v[1];
    assign if2.AXIS_TX_TREADY = rdy_v[2];

    assign o_data[0]  = 512'(if0.AXIS_TX_TDATA);
    assign o_data[1]  = 512'(if1.AXIS_TX_TDATA);
    assign o_data[2]  = 512'(if2.AXIS_TX_TDATA);
    assign o_keep[0]  = 64'(if0.AXIS_TX_TKEEP);
    assign o_keep[1]  = 64'(if1.AXIS_TX_TKEEP);
    assign o_keep[2]  = 64'(if2.AXIS_TX_TKEEP);
    assign o_user[0]  = if0.AXIS_TX_TUSER;
    assign o_user[1]  = if1.AXIS_TX_TUSER;
    assign o_user[2]  = if2.AXIS_TX_TUSER;
    assign o_last[0]  = if0.AXIS_TX_TLAST;
    assign o_last[1]  = if1.AXIS_TX_TLAST;
    assign o_last[2]  = if2.AXIS_TX_TLAST;
    assign o_valid[0] = if0.AXIS_TX_TVALID;
    assign o_valid[1] = if1.AXIS_TX_TVALID;
    assign o_valid[2] = if2.AXIS_TX_TVALID;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         user;
        logic         last;
    } beat_t;

    typedef struct {
        int     idx;
        int     len;
        longint cnt;
        int     rmode;   // 0: ready held 1, 1: random ready
        int     beats;
    } vec_t;

    int    n_vec = 0;
    int    n_err = 0;
    int    act = 0;
    bit    mon_en = 1'b0;
    int    cyc = 0;
    int    done_exp_at = -10;
    bit    done_seen = 1'b0;
    int    beats_seen = 0;
    int    start_cyc = 0;
    int    rdy_mode = 0;  // 2: manual, value in rdy_man
    logic  rdy_man = 1'b0;
    int    hs_cyc [$];
    beat_t expq [$];
    bit    stall_prev = 1'b0;
    beat_t stall_b;
    beat_t got;
    beat_t exp_b;

    // ------------------------------------------------------------- model
    function automatic int bpb_of(int idx);
        return (idx == 1) ? 8 : 4;
    endfunction

    function automatic logic [31:0] seed_word();
`ifdef DATA_PRODUCER_PRBS_EN
        return 32'hFFFF_FFFF;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] next_word(logic [31:0] w);
`ifdef DATA_PRODUCER_PRBS_EN
        return {1'b0, w[31:1]} ^ (w[0] ? 32'h8020_0003 : 32'h0);
`else
        return w + 32'd1;
`endif
    endfunction

    // Expand a command into its byte stream, cut into bus-width beats.
    task automatic model_cmd(input int idx, input int len, input longint cnt);
        int bpb;
        int nb;
        logic [31:0] word;
        bpb  = bpb_of(idx);
        word = seed_word();
        if (len == 0 || cnt == 0) return;
        nb = (len + bpb - 1) / bpb;
        for (longint p = 0; p < cnt; p++) begin
            for (int b = 0; b < nb; b++) begin
                beat_t e;
                int left;
                int nbytes;
                left   = len - b * bpb;
                nbytes = (left < bpb) ? left : bpb;
                e = '0;
                for (int i = 0; i < nbytes; i++) begin
                    e.keep[i] = 1'b1;
                    e.data[8*i +: 8] = word[8*(i%4) +: 8];
                end
                e.user = (b == 0);
                e.last = (b == nb - 1);
                expq.push_back(e);
                word = next_word(word);
            end
        end
    endtask

    // ------------------------------------------------------- ready driver
    initial begin
        for (int i = 0; i < 3; i++) rdy_v[i] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      rdy_v[act] = 1'b1;
            else if (rdy_mode == 1) rdy_v[act] = 1'($urandom_range(0, 1));
            else                    rdy_v[act] = rdy_man;
        end
    end

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (mon_en) begin
            got = {o_data[act], o_keep[act], o_user[act], o_last[act]};

            if (stall_prev) begin
                n_vec++;
                if (!o_valid[act] || got != stall_b) begin
                    n_err++;
                    $display("FAIL hold dut%0d cyc%0d: got valid=%b data=%h, required valid=1 data=%h",
                             act, cyc, o_valid[act], got.data[63:0], stall_b.data[63:0]);
                end
            end

            if (o_valid[act]) begin
                n_vec++;
                if (!o_busy[act]) begin
                    n_err++;
                    $display("FAIL busy_during_send dut%0d cyc%0d: got busy=0, required 1", act, cyc);
                end
            end

            if (o_valid[act] && rdy_v[act]) begin
                hs_cyc.push_back(cyc);
                beats_seen++;
                n_vec++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat dut%0d cyc%0d: got beat data=%h, required no beat",
                             act, cyc, got.data[63:0]);
                end else begin
                    exp_b = expq.pop_front();
                    if (got != exp_b) begin
                        n_err++;
                        $display("FAIL beat%0d dut%0d: got data=%h keep=%h user=%b last=%b, required data=%h keep=%h user=%b last=%b",
                                 beats_seen - 1, act, got.data[63:0], got.keep, got.user, got.last,
                                 exp_b.data[63:0], exp_b.keep, exp_b.user, exp_b.last);
                    end
                    if (expq.size() == 0) done_exp_at = cyc + 1;
                end
            end

            stall_prev = o_valid[act] && !rdy_v[act];
            stall_b    = got;

            if (o_done[act] || cyc == done_exp_at) begin
                n_vec++;
                if (o_done[act] != (cyc == done_exp_at) || (o_done[act] && o_busy[act])) begin
                    n_err++;
                    $display("FAIL done dut%0d cyc%0d: got done=%b busy=%b, required done=%b busy=0",
                             act, cyc, o_done[act], o_busy[act], (cyc == done_exp_at));
                end
                if (o_done[act]) done_seen = 1'b1;
            end

            for (int i = 0; i < 3; i++) begin
                if (i != act && o_valid[i]) begin
                    n_err++;
                    $display("FAIL idle_valid dut%0d cyc%0d: got valid=1, required 0", i, cyc);
                end
            end
        end
        cyc++;
    end

    // ---------------------------------------------------------- commands
    task automatic issue_cmd(input int idx, input int len, input longint cnt, input int rmode);
        @(posedge clk);
        #1;
        act        = idx;
        rdy_mode   = rmode;
        done_seen  = 1'b0;
        beats_seen = 0;
        stall_prev = 1'b0;
        hs_cyc.delete();
        expq.delete();
        model_cmd(idx, len, cnt);
        start_v[idx] = 1'b1;
        len_v[idx]   = 16'(len);
        cnt_v[idx]   = 32'(cnt);
        start_cyc    = cyc;
        if (len == 0 || cnt == 0) done_exp_at = cyc + 1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        // Scramble the inputs: they must only be sampled with start.
        len_v[idx] = 16'($urandom);
        cnt_v[idx] = $urandom;
    endtask

    task automatic wait_done(input int exp_beats, input int budget);
        for (int k = 0; k < budget && !done_seen; k++) @(posedge clk);
        #2;
        n_vec++;
        if (!done_seen) begin
            n_err++;
            $display("FAIL timeout dut%0d: got no done within %0d clocks, required done", act, budget);
        end
        n_vec++;
        if (beats_seen != exp_beats || expq.size() != 0) begin
            n_err++;
            $display("FAIL beat_count dut%0d: got %0d beats (%0d left), required %0d",
                     act, beats_seen, expq.size(), exp_beats);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (o_valid[i] || o_busy[i] || o_done[i] || o_user[i] || o_last[i] ||
                o_data[i] != '0 || o_keep[i] != '0) begin
                n_err++;
                $display("FAIL %s dut%0d: got valid=%b busy=%b done=%b data=%h keep=%h user=%b last=%b, required all 0",
                         tag, i, o_valid[i], o_busy[i], o_done[i], o_data[i][63:0], o_keep[i],
                         o_user[i], o_last[i]);
            end
        end
    endtask

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{0, 10,    2, 0, 6};
        tbl[1]  = '{1, 8,     1, 0, 1};
        tbl[2]  = '{2, 24,    1, 0, 6};
        tbl[3]  = '{0, 0,     5, 0, 0};
        tbl[4]  = '{0, 5,     0, 0, 0};
        tbl[5]  = '{0, 1,     3, 1, 3};
        tbl[6]  = '{1, 17,    2, 1, 6};
        tbl[7]  = '{2, 7,     3, 1, 6};
        tbl[8]  = '{0, 65535, 1, 0, 16384};
        tbl[9]  = '{1, 64,    3, 1, 24};
        tbl[10] = '{0, 4,     1, 1, 1};

        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            len_v[i]   = 16'd0;
            cnt_v[i]   = 32'd0;
        end

        // Reset state, during and after reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_state");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset_state");
        mon_en = 1'b1;

        // Table-driven commands.
        foreach (tbl[t]) begin
            issue_cmd(tbl[t].idx, tbl[t].len, tbl[t].cnt, tbl[t].rmode);
            wait_done(tbl[t].beats, tbl[t].beats * 6 + 50);
        end

        // Back-to-back beats, first beat one cycle after start is sampled.
        issue_cmd(0, 10, 2, 0);
        wait_done(6, 60);
        n_vec++;
        if (hs_cyc.size() != 6 || hs_cyc[0] != start_cyc + 1 || hs_cyc[5] != start_cyc + 6) begin
            n_err++;
            $display("FAIL stream_timing: got %0d beats first@+%0d, required 6 beats first@+1 last@+6",
                     hs_cyc.size(), (hs_cyc.size() > 0) ? hs_cyc[0] - start_cyc : -1);
        end

        // Throttled source: 2 beats, 3 idle clocks, repeated.
        issue_cmd(2, 24, 1, 0);
        wait_done(6, 80);
        begin
            int offs [6];
            offs = '{0, 1, 5, 6, 10, 11};
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (i >= hs_cyc.size() || hs_cyc[i] - hs_cyc[0] != offs[i]) begin
                    n_err++;
                    $display("FAIL gap_pattern beat%0d: got offset %0d, required %0d", i,
                             (i < hs_cyc.size()) ? hs_cyc[i] - hs_cyc[0] : -1, offs[i]);
                end
            end
        end

        // Backpressure: DW=64 beat held for 5 clocks before acceptance.
        rdy_man = 1'b0;
        issue_cmd(1, 8, 1, 2);
        repeat (6) @(posedge clk);
        #2;
        n_vec++;
        if (!o_valid[1] || o_data[1] != '0 || o_keep[1] != 64'hFF || !o_user[1] || !o_last[1]) begin
            n_err++;
            $display("FAIL stall_beat: got valid=%b data=%h keep=%h user=%b last=%b, required 1 0 ff 1 1",
                     o_valid[1], o_data[1][63:0], o_keep[1], o_user[1], o_last[1]);
        end
        rdy_man = 1'b1;
        wait_done(1, 40);

        // Zero length: done exactly one cycle after start, busy never rises.
        issue_cmd(0, 0, 5, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (o_busy[0] || o_valid[0]) begin
                n_err++;
                $display("FAIL zero_len_busy: got busy=%b valid=%b, required 0 0", o_busy[0], o_valid[0]);
            end
        end
        wait_done(0, 10);

        // start while busy is ignored.
        issue_cmd(0, 12, 2, 0);
        repeat (2) @(posedge clk);
        #1;
        start_v[0] = 1'b1;
        len_v[0]   = 16'd4;
        cnt_v[0]   = 32'd1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(6, 60);

        // start during the done cycle is ignored.
        issue_cmd(0, 8, 1, 0);
        for (int k = 0; k < 40 && !o_done[0]; k++) begin
            @(posedge clk);
            #1;
        end
        start_v[0] = 1'b1;
        len_v[0]   = 16'd4;
        cnt_v[0]   = 32'd1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        n_vec++;
        if (beats_seen != 2 || o_busy[0]) begin
            n_err++;
            $display("FAIL start_in_done: got %0d beats busy=%b, required 2 beats busy=0", beats_seen, o_busy[0]);
        end

        // Reset mid-packet while beat 3 of 8 is presented.
        issue_cmd(0, 32, 1, 0);
        for (int k = 0; k < 50 && beats_seen < 3; k++) @(posedge clk);
        #1;
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        check_idle_outputs("reset_mid_packet");
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        stall_prev = 1'b0;
        done_exp_at = -10;
        mon_en = 1'b1;
        issue_cmd(0, 10, 2, 0);
        wait_done(6, 60);

        // Randomized commands on random producers with random backpressure.
        for (int r = 0; r < 10; r++) begin
            int idx;
            int len;
            int cnt;
            int nb;
            idx = $urandom_range(0, 2);
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 70);
            cnt = $urandom_range(0, 4);
            nb  = (len == 0 || cnt == 0) ? 0 : ((len + bpb_of(idx) - 1) / bpb_of(idx)) * cnt;
            issue_cmd(idx, len, cnt, 1);
            wait_done(nb, nb * 20 + 100);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_producer.md
Name: data_producer

Overview:
- Dummy AXI-Stream packet source for bench and bring-up use. It sits directly upstream of the dummy stream consumer and drives its RX stream.
- On a start pulse it emits `packet_count` packets of `packet_len` bytes each. The payload is deterministic, so downstream checkers can verify ordering and byte counts.
- Optional TVALID throttling exercises gaps on the upstream side.

Parameters:
- DW, 32, data width in bits; legal values 32/64/128/256/512.
- VALID_CYCLES, 0, number of accepted beats before a throttle gap is inserted.
- NVALID_CYCLES, 0, length of each throttle gap in clocks; 0 disables throttling.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle command pulse
- packet_len  in  16  bytes per packet; sampled on start
- packet_count  in  32  number of packets; sampled on start
- busy  out  1  high while a command is executing
- done  out  1  one-cycle pulse when a command completes
- AXIS_TX_TDATA  out  DW  payload
- AXIS_TX_TKEEP  out  DW/8  byte enables
- AXIS_TX_TUSER  out  1  start-of-packet marker
- AXIS_TX_TLAST  out  1  last beat of packet
- AXIS_TX_TVALID  out  1  beat valid
- AXIS_TX_TREADY  in  1  downstream ready

Behaviour:
- Reset values: busy=0, done=0, TVALID=0, TDATA=0, TKEEP=0, TUSER=0, TLAST=0. FSM goes to IDLE and all counters clear.
- TVALID = resetn & (state==SEND), so it drops in the same cycle resetn falls. A reset mid-packet abandons the packet; no TLAST is sent.
- Define BPB = DW/8 (bytes per beat).
- Define beats per packet = ceil(packet_len/BPB), computed from the latched length.
- States:
  - IDLE:
    - start is honoured only here; packet_len and packet_count are latched.
    - If either is 0: no beats are sent, done pulses next cycle, busy stays 0.
    - Otherwise go to SEND next cycle; busy=1 from that cycle.
  - SEND:
    - Handshake = TVALID & TREADY.
    - On handshake: advance the beat and packet counters.
    - If the beat just accepted was the final beat of the final packet: go to IDLE, busy=0, done=1 for that one cycle.
    - Else if NVALID_CYCLES!=0 and VALID_CYCLES accepted beats have been counted since the last gap: go to GAP.
  - GAP: TVALID=0 for exactly NVALID_CYCLES clocks, then return to SEND and reset the beat-since-gap count.
- Gaps are entered only after a handshake. A beat, once presented, is never withdrawn.
- TDATA/TKEEP/TUSER/TLAST are held stable while TVALID=1 and TREADY=0.
- Payload:
  - seq is a 32-bit beat counter, cleared on start and incremented per handshake. It continues across packets and wraps 0xFFFFFFFF→0.
  - TDATA = seq replicated DW/32 times.
  - On the last beat, byte lanes with TKEEP=0 are driven 0.
- TKEEP:
  - All ones except on the last beat.
  - On the last beat, r = packet_len mod BPB. TKEEP = all ones if r==0, else the low r bits set.
- TUSER=1 on the first beat of each packet only. TLAST=1 on the last beat of each packet only.
- A single-beat packet has TUSER=1 and TLAST=1 together.
- start while busy, or in the done cycle, is ignored.
- packet_len=1 gives one beat with TKEEP=1; packet_len=0xFFFF is legal.

Optional Feature:
- Macro: DATA_PRODUCER_PRBS_EN.
- With the macro defined:
  - TDATA lanes come from a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, seeded 0xFFFFFFFF on start.
  - The LFSR advances once per handshake, replicated across lanes exactly like seq.
  - TKEEP masking still applies.
- Without the macro: the incrementing seq pattern described above.

Test Plan:
- DW=32, TREADY=1, start with len=10, count=2 → 6 beats. Seq values 0..5. TUSER on beats 0 and 3, TLAST on beats 2 and 5, TKEEP=0x3 on beats 2 and 5. done 1 cycle after beat 5.
- DW=64, len=8, count=1, TREADY held 0 for 5 clocks then 1 → TVALID stays high and TDATA=0x0000000000000000 is stable until accepted. TKEEP=0xFF, TUSER=TLAST=1.
- VALID_CYCLES=2, NVALID_CYCLES=3, len=24 (DW=32), TREADY=1 → pattern of 2 beats then 3 idle clocks, repeated. Total of 6 beats.
- len=0, count=5 → no TVALID; done pulses exactly 1 cycle after start; busy never asserts.
- resetn pulled low mid-packet (beat 3 of 8) → TVALID=0 in the same cycle and all outputs at reset values. A fresh start afterwards restarts seq at 0.
- start pulsed while busy with len=4 → ignored; the original command completes with the original length and count.
